// File: rtl/bit_adder_unit.sv
// Half- and full-adder datapath over WIDTH bits with ripple carry.
// Outputs are combinational, or registered once when REG_OUT=1.

module bit_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module bit_adder_unit #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sh,
    output logic             coh,
    output logic [WIDTH-1:0] sf,
    output logic             cof
);
    logic [WIDTH:0]   ch;
    logic [WIDTH:0]   cf;
    logic [WIDTH-1:0] sh_c;
    logic [WIDTH-1:0] sf_c;

    // Half path is a full-adder chain with a grounded carry-in, so its bit 0
    // reduces to s=a^b, c=a&b.
    assign ch[0] = 1'b0;
    assign cf[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        bit_adder_cell u_half (
            .a  (a[i]),
            .b  (b[i]),
            .ci (ch[i]),
            .s  (sh_c[i]),
            .co (ch[i+1])
        );
        bit_adder_cell u_full (
            .a  (a[i]),
            .b  (b[i]),
            .ci (cf[i]),
            .s  (sf_c[i]),
            .co (cf[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sh  <= '0;
                coh <= 1'b0;
                sf  <= '0;
                cof <= 1'b0;
            end else begin
                sh  <= sh_c;
                coh <= ch[WIDTH];
                sf  <= sf_c;
                cof <= cf[WIDTH];
            end
        end
    end else begin : g_comb
        // Clock and reset are intentionally idle in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};

        assign sh  = sh_c;
        assign coh = ch[WIDTH];
        assign sf  = sf_c;
        assign cof = cf[WIDTH];
    end
endmodule

// File: tb/tb_bit_adder_unit.sv
// Checks combinational and registered builds of bit_adder_unit against
// plain unsigned addition.

module tb_bit_adder_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, ci = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;

    logic       sh1, coh1, sf1, cof1;
    logic [7:0] sh8, sf8;
    logic       coh8, cof8;
    logic       rsh1, rcoh1, rsf1, rcof1;
    logic [7:0] rsh8, rsf8;
    logic       rcoh8, rcof8;

    int total = 0;
    int bad   = 0;

    logic [1:0] p1h, p1f;
    logic [8:0] p8h, p8f;

    always #5 clk = ~clk;

    bit_adder_unit #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .ci(ci),
        .sh(sh1), .coh(coh1), .sf(sf1), .cof(cof1));
    bit_adder_unit #(.WIDTH(8), .REG_OUT(1'b0)) u_c8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(ci),
        .sh(sh8), .coh(coh8), .sf(sf8), .cof(cof8));
    bit_adder_unit #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .ci(ci),
        .sh(rsh1), .coh(rcoh1), .sf(rsf1), .cof(rcof1));
    bit_adder_unit #(.WIDTH(8), .REG_OUT(1'b1)) u_r8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(ci),
        .sh(rsh8), .coh(rcoh8), .sf(rsf8), .cof(rcof8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned WIDTH+1-bit sums of the current inputs.
    function automatic logic [1:0] m1(input logic x, input logic y, input logic c);
        return 2'(x) + 2'(y) + 2'(c);
    endfunction
    function automatic logic [8:0] m8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return 9'(x) + 9'(y) + 9'(c);
    endfunction

    task automatic chk_comb(input string tag);
        chk({tag, ".h1"}, 32'({coh1, sh1}), 32'(m1(a1, b1, 1'b0)));
        chk({tag, ".f1"}, 32'({cof1, sf1}), 32'(m1(a1, b1, ci)));
        chk({tag, ".h8"}, 32'({coh8, sh8}), 32'(m8(a8, b8, 1'b0)));
        chk({tag, ".f8"}, 32'({cof8, sf8}), 32'(m8(a8, b8, ci)));
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] e1h, input logic [1:0] e1f,
                           input logic [8:0] e8h, input logic [8:0] e8f);
        chk({tag, ".rh1"}, 32'({rcoh1, rsh1}), 32'(e1h));
        chk({tag, ".rf1"}, 32'({rcof1, rsf1}), 32'(e1f));
        chk({tag, ".rh8"}, 32'({rcoh8, rsh8}), 32'(e8h));
        chk({tag, ".rf8"}, 32'({rcof8, rsf8}), 32'(e8f));
    endtask

    task automatic rand_inputs();
        a1 = 1'($urandom); b1 = 1'($urandom); ci = 1'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    initial begin
        // Combinational builds; rst_n held low throughout must not matter.
        ci = 1'b0; a1 = 1'b1; b1 = 1'b0; #1;
        chk("w1 10c0 h", 32'({coh1, sh1}), 32'h1);
        chk("w1 10c0 f", 32'({cof1, sf1}), 32'h1);
        a1 = 1'b0; b1 = 1'b1; #1;
        chk("w1 01c0 f", 32'({cof1, sf1}), 32'h1);
        a1 = 1'b1; b1 = 1'b1; #1;
        chk("w1 11c0 h", 32'({coh1, sh1}), 32'h2);
        chk("w1 11c0 f", 32'({cof1, sf1}), 32'h2);
        a1 = 1'b0; b1 = 1'b0; #1;
        chk("w1 00c0 all", 32'({coh1, sh1, cof1, sf1}), 32'h0);
        ci = 1'b1; a1 = 1'b1; b1 = 1'b0; #1;
        chk("w1 10c1 h", 32'({coh1, sh1}), 32'h1);
        chk("w1 10c1 f", 32'({cof1, sf1}), 32'h2);
        a1 = 1'b0; b1 = 1'b1; #1;
        chk("w1 01c1 f", 32'({cof1, sf1}), 32'h2);
        a1 = 1'b1; b1 = 1'b1; #1;
        chk("w1 11c1 h", 32'({coh1, sh1}), 32'h2);
        chk("w1 11c1 f", 32'({cof1, sf1}), 32'h3);
        for (int v = 0; v < 8; v++) begin
            {a1, b1, ci} = 3'(v);
            #1 chk_comb($sformatf("sweep%0d", v));
        end
        a8 = 8'hFF; b8 = 8'h01; ci = 1'b1; #1;
        chk("w8 ff01c1 h", 32'({coh8, sh8}), 32'h100);
        chk("w8 ff01c1 f", 32'({cof8, sf8}), 32'h101);
        a8 = 8'hFF; b8 = 8'hFF; #1;
        chk("w8 wrap h", 32'({coh8, sh8}), 32'h1FE);
        chk("w8 wrap f", 32'({cof8, sf8}), 32'h1FF);
        for (int k = 0; k < 40; k++) begin
            rand_inputs();
            #1 chk_comb($sformatf("rnd%0d", k));
        end

        // Registered builds: reset holds outputs at zero.
        @(negedge clk); rand_inputs(); a8 = 8'hA5; a1 = 1'b1;
        @(posedge clk); #1;
        chk_reg("in_reset", 2'd0, 2'd0, 9'd0, 9'd0);

        // First result lands exactly one edge after release.
        @(negedge clk); rst_n = 1'b1; a1 = 1'b1; b1 = 1'b1; ci = 1'b1; a8 = 8'd1; b8 = 8'd1;
        #1 chk_reg("pre_edge", 2'd0, 2'd0, 9'd0, 9'd0);
        @(posedge clk); #1;
        chk_reg("first", 2'b10, 2'b11, 9'd2, 9'd3);
        p1h = 2'b10; p1f = 2'b11; p8h = 9'd2; p8f = 9'd3;

        // Stream: new operands every cycle, outputs move only on the edge.
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); rand_inputs();
            #1 chk_reg($sformatf("hold%0d", k), p1h, p1f, p8h, p8f);
            p1h = m1(a1, b1, 1'b0); p1f = m1(a1, b1, ci);
            p8h = m8(a8, b8, 1'b0); p8f = m8(a8, b8, ci);
            @(posedge clk); #1;
            chk_reg($sformatf("strm%0d", k), p1h, p1f, p8h, p8f);
        end

        // Mid-stream reset is synchronous and beats the incoming operands.
        @(negedge clk); rst_n = 1'b0; a1 = 1'b1; b1 = 1'b1; ci = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        #1 chk_reg("sync_rst_hold", p1h, p1f, p8h, p8f);
        @(posedge clk); #1;
        chk_reg("mid_rst", 2'd0, 2'd0, 9'd0, 9'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reg("wrap_reg", 2'b10, 2'b11, 9'h1FE, 9'h1FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
